// File: rtl/p2s_rr_scheduler_if.sv
// Parallel-word request bus and tagged serial output of the shared P2S shifter.
// master = word producers / link consumer side, slave = scheduler side.
interface p2s_rr_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 4,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] din;
  logic [NUM_REQ-1:0]        ack;
  logic                      dout;
  logic                      valid_out;
  logic [ID_W-1:0]           src_id;
  logic                      busy;

  modport master (
    output req, din,
    input  ack, dout, valid_out, src_id, busy
  );

  modport slave (
    input  req, din,
    output ack, dout, valid_out, src_id, busy
  );
endinterface

// File: rtl/p2s_rr_scheduler.sv
// Round-robin arbiter feeding one MSB-first parallel-to-serial shifter.
// Words reload back-to-back on the last bit; every output is registered.
module p2s_rr_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 4,
  parameter int ID_W    = 2
) (
  input logic                clk,
  input logic                rst_n,
  p2s_rr_scheduler_if.slave  bus
);

  localparam int CNT_W = $clog2(DATA_W);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t              state_q, state_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [ID_W-1:0]     src_id_q, src_id_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic                dout_q, dout_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;

  logic [DATA_W-1:0]   words [NUM_REQ];
  logic                gnt_found;
  logic [ID_W-1:0]     gnt_idx;
  logic                last_bit;
  logic                grant;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign words[gi] = bus.din[gi*DATA_W +: DATA_W];
  end

  assign last_bit = (cnt_q == CNT_W'(DATA_W - 1));

  // First pending request strictly after ptr, wrapping modulo NUM_REQ.
  always_comb begin : rr_pick
    int unsigned     idx;
    logic [ID_W-1:0] cand;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    cand      = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx  = (32'(ptr_q) + k) % NUM_REQ;
      cand = ID_W'(idx);
      if (!gnt_found && bus.req[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  assign grant = gnt_found && ((state_q == IDLE) || last_bit);

  always_comb begin : next_state
    state_d  = state_q;
    ptr_d    = ptr_q;
    src_id_d = src_id_q;
    cnt_d    = cnt_q;
    shreg_d  = shreg_q;
    ack_d    = '0;
    valid_d  = 1'b0;
    dout_d   = dout_q;
    busy_d   = busy_q;

    unique case (state_q)
      IDLE:  if (gnt_found) state_d = SHIFT;
      SHIFT: if (last_bit && !gnt_found) state_d = IDLE;
    endcase

    // dout is a separate register so it can be forced to 0 when idle
    // without disturbing src_id, which must hold its last value.
    if (grant) begin
      shreg_d        = words[gnt_idx];
      dout_d         = words[gnt_idx][DATA_W-1];
      cnt_d          = '0;
      ptr_d          = gnt_idx;
      src_id_d       = gnt_idx;
      ack_d[gnt_idx] = 1'b1;
      valid_d        = 1'b1;
      busy_d         = 1'b1;
    end else if (state_q == SHIFT && !last_bit) begin
      shreg_d = shreg_q << 1;
      dout_d  = shreg_q[DATA_W-2];
      cnt_d   = cnt_q + 1'b1;
      busy_d  = 1'b1;
    end else begin
      dout_d = 1'b0;
      busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ptr_q    <= ID_W'(NUM_REQ - 1);
      src_id_q <= '0;
      cnt_q    <= '0;
      shreg_q  <= '0;
      ack_q    <= '0;
      dout_q   <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      src_id_q <= src_id_d;
      cnt_q    <= cnt_d;
      shreg_q  <= shreg_d;
      ack_q    <= ack_d;
      dout_q   <= dout_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.ack       = ack_q;
  assign bus.dout      = dout_q;
  assign bus.valid_out = valid_q;
  assign bus.src_id    = src_id_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_p2s_rr_scheduler.sv
// Bench for p2s_rr_scheduler: cycle-level reference model pushes expected
// words into a scoreboard; a negedge monitor reassembles serial words.
module tb_p2s_rr_scheduler;
  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 4;
  localparam int ID_W    = 2;

  typedef struct {
    int                id;
    logic [DATA_W-1:0] w;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  p2s_rr_scheduler_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ID_W(ID_W)) bus_if ();

  p2s_rr_scheduler #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_if.slave)
  );

  int checks = 0;
  int fails  = 0;

  exp_t sbq[$];

  // Reference model: rotating priority pointer plus bits still to send.
  int m_ptr   = NUM_REQ - 1;
  int m_rem   = 0;
  bit m_shift = 1'b0;
  logic [NUM_REQ-1:0] sticky = '0;

  bit                mon_active = 1'b0;
  int                mon_cnt    = 0;
  logic [DATA_W-1:0] mon_word   = '0;
  exp_t              mon_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle();
    int                 g;
    bit                 found;
    logic [NUM_REQ-1:0] exp_ack;
    exp_t               e;
    @(posedge clk);
    #1;
    exp_ack = '0;
    found   = 1'b0;
    g       = 0;
    if (!m_shift || m_rem == 0) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        int idx;
        idx = (m_ptr + k) % NUM_REQ;
        if (!found && bus_if.req[idx]) begin
          found = 1'b1;
          g     = idx;
        end
      end
    end
    if (found) begin
      e.id = g;
      e.w  = bus_if.din[g*DATA_W +: DATA_W];
      sbq.push_back(e);
      m_ptr      = g;
      m_rem      = DATA_W - 1;
      m_shift    = 1'b1;
      exp_ack[g] = 1'b1;
      bus_if.req[g] = sticky[g];
      if (sticky[g]) bus_if.din[g*DATA_W +: DATA_W] = DATA_W'($urandom);
    end else if (m_shift && m_rem > 0) begin
      m_rem--;
    end else begin
      m_shift = 1'b0;
    end
    check("ack", 32'(bus_if.ack), 32'(exp_ack));
    check("busy", 32'(bus_if.busy), 32'(m_shift));
    check("valid_out", 32'(bus_if.valid_out), 32'(found));
    if (m_shift) check("src_id", 32'(bus_if.src_id), 32'(m_ptr));
    else         check("dout_idle", 32'(bus_if.dout), 32'd0);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      mon_active = 1'b0;
    end else if (bus_if.valid_out) begin
      if (mon_active) check("word_len", 32'(mon_cnt), 32'(DATA_W));
      check("sb_depth", 32'(sbq.size()), 32'd1);
      if (sbq.size() > 0) begin
        mon_exp    = sbq.pop_front();
        mon_word   = '0;
        mon_word[0] = bus_if.dout;
        mon_cnt    = 1;
        mon_active = 1'b1;
        check("first_src_id", 32'(bus_if.src_id), 32'(mon_exp.id));
      end
    end else if (mon_active) begin
      mon_word = {mon_word[DATA_W-2:0], bus_if.dout};
      mon_cnt++;
      if (mon_cnt == DATA_W) begin
        check("serial_word", 32'(mon_word), 32'(mon_exp.w));
        check("last_src_id", 32'(bus_if.src_id), 32'(mon_exp.id));
        mon_active = 1'b0;
      end
    end
  end

  initial begin
    bus_if.req = '0;
    bus_if.din = '0;
    #2 rst_n = 1'b0;
    #2;
    check("rst_ack", 32'(bus_if.ack), 32'd0);
    check("rst_dout", 32'(bus_if.dout), 32'd0);
    check("rst_valid", 32'(bus_if.valid_out), 32'd0);
    check("rst_src_id", 32'(bus_if.src_id), 32'd0);
    check("rst_busy", 32'(bus_if.busy), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Single word 1011 from requester 0.
    bus_if.din[3:0] = 4'b1011;
    bus_if.req      = 4'b0001;
    run(6);

    // All four pending: contiguous round-robin stream.
    bus_if.din = {4'hD, 4'hC, 4'hB, 4'hA};
    bus_if.req = 4'b1111;
    run(18);

    // Requesters 0 and 2 always pending: alternating grants.
    sticky = 4'b0101;
    bus_if.din[3:0]   = 4'h5;
    bus_if.din[11:8]  = 4'h6;
    bus_if.req = 4'b0101;
    run(16);
    sticky     = '0;
    bus_if.req = '0;
    run(6);

    // Wrap-around: last grant 3, then 0 and 3 pending.
    bus_if.din[15:12] = 4'h9;
    bus_if.req = 4'b1000;
    run(6);
    bus_if.din[3:0]   = 4'h3;
    bus_if.din[15:12] = 4'h6;
    bus_if.req = 4'b1001;
    run(10);

    // din changed mid-shift must not alter the serial word.
    bus_if.din[7:4] = 4'hC;
    bus_if.req = 4'b0010;
    cycle();
    bus_if.din[7:4] = 4'h3;
    run(5);

    // Reset while bit 2 of a word is on dout.
    bus_if.din[3:0] = 4'hE;
    bus_if.req = 4'b0001;
    cycle();
    cycle();
    #2 rst_n = 1'b0;
    #1;
    check("midrst_dout", 32'(bus_if.dout), 32'd0);
    check("midrst_valid", 32'(bus_if.valid_out), 32'd0);
    check("midrst_busy", 32'(bus_if.busy), 32'd0);
    check("midrst_ack", 32'(bus_if.ack), 32'd0);
    check("midrst_src_id", 32'(bus_if.src_id), 32'd0);
    sbq.delete();
    m_ptr   = NUM_REQ - 1;
    m_rem   = 0;
    m_shift = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    bus_if.din[3:0]   = 4'h7;
    bus_if.din[15:12] = 4'hE;
    bus_if.req = 4'b1001;
    run(10);

    // Random traffic including withdrawals and re-requests in the ack cycle.
    for (int c = 0; c < 600; c++) begin
      cycle();
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!bus_if.req[i]) begin
          bus_if.din[i*DATA_W +: DATA_W] = DATA_W'($urandom);
          if ($urandom_range(0, 2) == 0) bus_if.req[i] = 1'b1;
        end else if ($urandom_range(0, 19) == 0) begin
          bus_if.req[i] = 1'b0;
        end
      end
    end
    bus_if.req = '0;
    run(DATA_W + 3);
    check("sb_drain", 32'(sbq.size()), 32'd0);
    check("mon_idle", 32'(mon_active), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
